// File: rtl/clk_gen_pkg.sv
// Shared constants for the divided-clock generator: FSM state encoding and
// default parameter values.
package clk_gen_pkg;

    localparam int unsigned NCH_DEF          = 4;
    localparam int unsigned CNT_W_DEF        = 8;
    localparam int unsigned RST_PULSE_DEF    = 16;
    localparam int unsigned LOCK_TIMEOUT_DEF = 4096;
    localparam int unsigned LOCK_CYCLES_DEF  = 256;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_RST_DCM   = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [ST_W-1:0] ST_STABLE    = 2'd2;
    localparam logic [ST_W-1:0] ST_RUN       = 2'd3;

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: a shadow divide/phase register, the active divide
// ratio, a wrapping counter and registered clock/enable outputs.
module clk_div_chan #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,    // FSM currently in RUN
    input  logic             oen_i,    // FSM in RUN next cycle
    input  logic             load_i,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] phase_i,
    output logic             clk_o,
    output logic             ce_o
);

    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0] sh_div_q, sh_ph_q, cur_div_q, cnt_q;
    logic [CNT_W-1:0] cur_div_d, cnt_d;
    logic [CNT_W-1:0] new_div, new_ph, new_eff;
    logic [CNT_W:0]   half_d;
    logic             clk_q, ce_q, clk_d, ce_d, en_d, wrap;

    // A load in this cycle is visible at once, so load+sync act together.
    assign new_div = load_i ? div_i : sh_div_q;
    assign new_ph  = load_i ? phase_i : sh_ph_q;
    assign new_eff = (new_ph < new_div) ? new_ph : '0;
    assign wrap    = (cnt_q == cur_div_q - 1'b1);

    always_comb begin
        cur_div_d = cur_div_q;
        cnt_d     = cnt_q;
        if (!run_i || (cur_div_q < TWO) || sync_i) begin
            cur_div_d = new_div;
            cnt_d     = new_eff;
        end else if (wrap) begin
            cur_div_d = new_div;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from next-state so the flops track the counter exactly.
    always_comb begin
        en_d   = oen_i && (cur_div_d >= TWO);
        half_d = ({1'b0, cur_div_d} + 1'b1) >> 1;
        clk_d  = en_d && ({1'b0, cnt_d} < half_d);
        ce_d   = en_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_div_q  <= '0;
            sh_ph_q   <= '0;
            cur_div_q <= '0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            sh_div_q  <= new_div;
            sh_ph_q   <= new_ph;
            cur_div_q <= cur_div_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            ce_q      <= ce_d;
        end
    end

    assign clk_o = clk_q;
    assign ce_o  = ce_q;

endmodule

// File: rtl/clk_div_gen.sv
// Divided-clock generator: sequences the upstream DCM reset/lock handshake and
// runs NCH programmable clock-divider channels once lock is stable.
module clk_div_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned NCH          = NCH_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned RST_PULSE    = RST_PULSE_DEF,
    parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int unsigned LOCK_CYCLES  = LOCK_CYCLES_DEF
) (
    input  logic               CLKIN_IN,
    input  logic               RST_IN,
    input  logic               LOCKED_IN,
    output logic               DCM_RST_OUT,
    input  logic [NCH*CNT_W-1:0] DIV_IN,
    input  logic [NCH*CNT_W-1:0] PHASE_IN,
    input  logic               LOAD_IN,
    input  logic               SYNC_IN,
    output logic [NCH-1:0]     CLK_OUT,
    output logic [NCH-1:0]     CE_OUT,
    output logic               READY_OUT,
    output logic [7:0]         RETRY_CNT_OUT
);

    localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + LOCK_CYCLES + RST_PULSE + 1);
    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STAB_LAST = TMR_W'(LOCK_CYCLES - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       retry_q, retry_d;
    logic             retry_inc;
    logic             lock_meta_q, lock_sync_q;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + 1'b1;
        retry_inc = 1'b0;
        case (state_q)
            ST_RST_DCM: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = ST_STABLE;
                    tmr_d   = '0;
                end else if (tmr_q == TOUT_LAST) begin
                    state_d   = ST_RST_DCM;
                    tmr_d     = '0;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == STAB_LAST) begin
                    state_d = ST_RUN;
                    tmr_d   = '0;
                end
            end
            ST_RUN: begin
                tmr_d = '0;
                if (!lock_sync_q) begin
                    state_d   = ST_RST_DCM;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_DCM;
                tmr_d   = '0;
            end
        endcase
    end

    assign retry_d = (retry_inc && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;

    always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q     <= ST_RST_DCM;
            tmr_q       <= '0;
            retry_q     <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            lock_meta_q <= LOCKED_IN;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign DCM_RST_OUT   = (state_q == ST_RST_DCM);
    assign READY_OUT     = (state_q == ST_RUN);
    assign RETRY_CNT_OUT = retry_q;

    logic run_now, run_next;
    assign run_now  = (state_q == ST_RUN);
    assign run_next = (state_d == ST_RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk_i  (CLKIN_IN),
            .rst_i  (RST_IN),
            .run_i  (run_now),
            .oen_i  (run_next),
            .load_i (LOAD_IN),
            .sync_i (SYNC_IN),
            .div_i  (DIV_IN[i*CNT_W +: CNT_W]),
            .phase_i(PHASE_IN[i*CNT_W +: CNT_W]),
            .clk_o  (CLK_OUT[i]),
            .ce_o   (CE_OUT[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: lock/reset sequencing checks plus a scoreboard that
// compares divided clocks against a time-based reference model.
module tb_clk_div_gen;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b1;
    logic sat_locked = 1'b0;
    logic load = 1'b0;
    logic sync = 1'b0;
    logic [NCH*CNT_W-1:0] div = '0;
    logic [NCH*CNT_W-1:0] phase = '0;

    logic           dcm_rst, ready;
    logic [NCH-1:0] clk_out, ce_out;
    logic [7:0]     retry;
    logic           sat_dcm_rst, sat_ready;
    logic [NCH-1:0] sat_clk, sat_ce;
    logic [7:0]     sat_retry;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_div_gen dut (
        .CLKIN_IN     (clk),
        .RST_IN       (rst),
        .LOCKED_IN    (locked),
        .DCM_RST_OUT  (dcm_rst),
        .DIV_IN       (div),
        .PHASE_IN     (phase),
        .LOAD_IN      (load),
        .SYNC_IN      (sync),
        .CLK_OUT      (clk_out),
        .CE_OUT       (ce_out),
        .READY_OUT    (ready),
        .RETRY_CNT_OUT(retry)
    );

    // Short timeouts so retry saturation is reachable in a short run.
    clk_div_gen #(
        .RST_PULSE   (2),
        .LOCK_TIMEOUT(8),
        .LOCK_CYCLES (4)
    ) dut_sat (
        .CLKIN_IN     (clk),
        .RST_IN       (rst),
        .LOCKED_IN    (sat_locked),
        .DCM_RST_OUT  (sat_dcm_rst),
        .DIV_IN       (div),
        .PHASE_IN     (phase),
        .LOAD_IN      (load),
        .SYNC_IN      (sync),
        .CLK_OUT      (sat_clk),
        .CE_OUT       (sat_ce),
        .READY_OUT    (sat_ready),
        .RETRY_CNT_OUT(sat_retry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each enabled channel is a periodic waveform of period
    // md whose count-0 instant is anchored at cycle org.
    typedef struct {
        int             c;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] ce;
    } exp_t;

    exp_t sb_q[$];
    int   md[NCH];
    int   sd[NCH];
    int   sp[NCH];
    int   org[NCH];

    function automatic int eff(input int d, input int p);
        return (p < d) ? p : 0;
    endfunction

    task automatic model_push(input int t);
        exp_t e;
        e.c  = t;
        e.ck = '0;
        e.ce = '0;
        for (int i = 0; i < NCH; i++) begin
            if (md[i] >= 2) begin
                int pos;
                pos      = (t - org[i]) % md[i];
                e.ck[i]  = (pos < (md[i] + 1) / 2);
                e.ce[i]  = (pos == 0);
            end
        end
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs (called #1 after a rising edge) and predict
    // the outputs of the following cycle.
    task automatic step(input bit ld, input bit sy,
                        input logic [NCH*CNT_W-1:0] dv, input logic [NCH*CNT_W-1:0] ph);
        int t;
        load = ld;
        sync = sy;
        if (ld) begin
            div   = dv;
            phase = ph;
        end
        t = cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            int nd, np;
            nd = ld ? int'(dv[i*CNT_W +: CNT_W]) : sd[i];
            np = ld ? int'(ph[i*CNT_W +: CNT_W]) : sp[i];
            if (md[i] < 2 || sy) begin
                md[i]  = nd;
                org[i] = t - eff(nd, np);
            end else if (((t - org[i]) % md[i]) == 0) begin
                md[i]  = nd;
                org[i] = t;
            end
            sd[i] = nd;
            sp[i] = np;
        end
        model_push(t);
        @(posedge clk);
        #1;
        load = 1'b0;
        sync = 1'b0;
    endtask

    // Monitor: pops expectations as their cycle comes up.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].c < cyc) begin
            e = sb_q.pop_front();
            check("sb_stale_entry", 32'(e.c), 32'(cyc));
        end
        if (sb_q.size() > 0 && sb_q[0].c == cyc) begin
            e = sb_q.pop_front();
            check("sb_clk_out", 32'(clk_out), 32'(e.ck));
            check("sb_ce_out", 32'(ce_out), 32'(e.ce));
            check("sb_ready", 32'(ready), 32'd1);
        end
    end

    // The saturating retry counter must never move backwards.
    logic [7:0] sat_prev = '0;
    bit         sat_bad  = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (sat_retry < sat_prev) sat_bad = 1'b1;
            sat_prev = sat_retry;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi, rdy_at, got, hi, gap;
        bit bad_out;
        logic [7:0] prev;
        logic [NCH*CNT_W-1:0] dv, ph;

        for (int i = 0; i < NCH; i++) begin
            md[i] = 0; sd[i] = 0; sp[i] = 0; org[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_dcm_rst", 32'(dcm_rst), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_ce_out", 32'(ce_out), 32'd0);
        check("rst_retry", 32'(retry), 32'd0);
        rst = 1'b0;

        // Lock present from the start: measure DCM reset pulse and time to RUN.
        n_hi    = 0;
        rdy_at  = -1;
        bad_out = 1'b0;
        for (int k = 0; k < 400 && rdy_at < 0; k++) begin
            @(negedge clk);
            if (dcm_rst) n_hi++;
            if (ready) rdy_at = k;
            else if (clk_out != '0 || ce_out != '0) bad_out = 1'b1;
        end
        check("pulse_len_initial", 32'(n_hi), 32'd16);
        check("ready_latency_in_window", (rdy_at >= 273 && rdy_at <= 275) ? 32'd1 : 32'd0, 32'd1);
        check("outputs_zero_before_run", 32'(bad_out), 32'd0);

        @(posedge clk);
        #1;
        model_push(cyc);

        // D = {0,5,3,2} (channel 3 down to 0), phase 0.
        step(1'b1, 1'b0, 32'h0005_0302, 32'h0);
        repeat (20) step(1'b0, 1'b0, '0, '0);

        // Channel 0 to 4, then 4 -> 6 part-way through a period.
        step(1'b1, 1'b0, 32'h0005_0304, 32'h0);
        repeat (13) step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'h0005_0306, 32'h0);
        repeat (20) step(1'b0, 1'b0, '0, '0);

        // All D=4, P={0,1,2,9}, then realign.
        step(1'b1, 1'b0, 32'h0404_0404, 32'h0902_0100);
        repeat (9) step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, '0, '0);
        check("sync_ce_out", 32'(ce_out), 32'h9);
        check("sync_clk_out", 32'(clk_out), 32'hB);
        repeat (10) step(1'b0, 1'b0, '0, '0);

        // Random loads (including back-to-back pending loads) and syncs.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                dv[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 7));
                ph[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
            end
            step($urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0, dv, ph);
        end
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // Lock loss in RUN.
        @(posedge clk);
        #1;
        prev = retry;
        check("retry_before_drop", 32'(prev), 32'd0);
        locked = 1'b0;
        got = -1;
        for (int k = 1; k <= 5 && got < 0; k++) begin
            @(posedge clk);
            #1;
            if (!ready && clk_out == '0 && ce_out == '0) got = k;
        end
        check("drop_latency_in_window", (got >= 1 && got <= 3) ? 32'd1 : 32'd0, 32'd1);
        check("drop_dcm_rst", 32'(dcm_rst), 32'd1);
        check("drop_retry_inc", 32'(retry), 32'(prev) + 32'd1);

        // Lock stays low: periodic retries.
        for (int r = 0; r < 2; r++) begin
            hi = 0;
            while (dcm_rst && hi < 100) begin
                hi++;
                @(posedge clk);
                #1;
            end
            check("retry_pulse_len", 32'(hi), 32'd16);
            gap = 0;
            while (!dcm_rst && gap < 5000) begin
                gap++;
                @(posedge clk);
                #1;
            end
            check("retry_period", 32'(hi + gap), 32'd4112);
            check("retry_count", 32'(retry), 32'(prev) + 32'd2 + 32'(r));
            check("retry_not_ready", 32'(ready), 32'd0);
        end

        check("sat_retry_255", 32'(sat_retry), 32'd255);
        check("sat_monotonic", 32'(sat_bad), 32'd0);
        check("sat_not_ready", 32'(sat_ready), 32'd0);
        check("sat_outputs_zero", 32'({sat_clk, sat_ce}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of divided-clock channels.
REQ-002 SHALL have parameter CNT_W, default 8, the width of each divide/phase field.
REQ-003 SHALL have parameter RST_PULSE, default 16, the DCM reset pulse length in cycles.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 4096, the cycles to wait for lock before retrying.
REQ-005 SHALL have parameter LOCK_CYCLES, default 256, the consecutive locked cycles required before run.
REQ-006 SHALL have port CLKIN_IN, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-007 SHALL have port RST_IN, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port LOCKED_IN, input, 1 bit: upstream DCM lock, asynchronous to CLKIN_IN.
REQ-009 SHALL have port DCM_RST_OUT, output, 1 bit: reset to the upstream DCM.
REQ-010 SHALL have port DIV_IN, input, NCH*CNT_W bits: per-channel divide ratio D, with channel i at [i*CNT_W +: CNT_W].
REQ-011 SHALL have port PHASE_IN, input, NCH*CNT_W bits: per-channel start count P.
REQ-012 SHALL have port LOAD_IN, input, 1 bit: a one-cycle strobe that captures DIV_IN/PHASE_IN into shadow registers.
REQ-013 SHALL have port SYNC_IN, input, 1 bit: a one-cycle strobe that realigns all channel counters.
REQ-014 SHALL have port CLK_OUT, output, NCH bits: registered divided clocks.
REQ-015 SHALL have port CE_OUT, output, NCH bits: one-cycle enable pulse per divided period.
REQ-016 SHALL have port READY_OUT, output, 1 bit: high while the FSM is in RUN.
REQ-017 SHALL have port RETRY_CNT_OUT, output, 8 bits: count of DCM reset retries, saturating at 255.

Function
REQ-018 SHALL synchronise LOCKED_IN through two flops; the FSM sees lock 2 cycles late.
REQ-019 SHALL implement the FSM RST_DCM -> WAIT_LOCK -> STABLE -> RUN, entering RST_DCM on reset.
REQ-020 In RST_DCM, SHALL hold DCM_RST_OUT=1 for exactly RST_PULSE cycles, then go to WAIT_LOCK.
REQ-021 In WAIT_LOCK, on synchronised lock=1 SHALL go to STABLE; after LOCK_TIMEOUT cycles without lock SHALL go to RST_DCM and increment the retry count.
REQ-022 In STABLE, after LOCK_CYCLES consecutive lock=1 cycles SHALL go to RUN; any lock=0 SHALL return to WAIT_LOCK with the timeout counter cleared.
REQ-023 In RUN, on lock=0 SHALL go to RST_DCM and increment the retry count; CLK_OUT and CE_OUT SHALL be 0 from the next cycle.
REQ-024 Outside RUN, SHALL hold each counter at its effective phase and force CLK_OUT and CE_OUT to 0.
REQ-025 Per channel, SHALL disable the channel (counter frozen, outputs 0) when D<2.
REQ-026 For D>=2, the counter SHALL count 0..D-1 and wrap to 0.
REQ-027 CLK_OUT[i] SHALL be 1 while count < (D+1)>>1, so odd D gives the longer half high.
REQ-028 CE_OUT[i] SHALL be 1 exactly in cycles where count==0, coincident with the CLK_OUT rising edge.
REQ-029 CLK_OUT and CE_OUT SHALL be driven directly from flops, with no combinational decode on the outputs.
REQ-030 The effective phase SHALL be P if P<D, else 0.
REQ-031 LOAD_IN SHALL capture into shadow; each channel SHALL adopt the new D at its next wrap, starting at count 0.
REQ-032 A channel that is disabled or outside RUN SHALL adopt the new D immediately.
REQ-033 SYNC_IN in RUN SHALL set every enabled counter to its effective phase on the next cycle.
REQ-034 On LOAD_IN and SYNC_IN in the same cycle, the new D and P SHALL take effect together on the next cycle.
REQ-035 A LOAD_IN that arrives while a previous load is still pending SHALL overwrite the shadow, last write wins.

Reset
REQ-036 RST_IN SHALL set the FSM to RST_DCM and clear all counters and the retry count.
REQ-037 RST_IN SHALL reset shadow D and P to 0, so all channels are disabled.
REQ-038 Output values during reset SHALL be: DCM_RST_OUT=1, READY_OUT=0, CLK_OUT=0, CE_OUT=0, RETRY_CNT_OUT=0.
REQ-039 RST_IN asserted mid-operation SHALL abort immediately, with no completion of the current period.

Structure
REQ-040 The FSM state encoding and default parameter constants SHALL live in the shared clk_gen_pkg package.
REQ-041 One sub-module, clk_div_chan (one counter, one shadow register, output flops), SHALL be instantiated NCH times.

Verification
REQ-042 Bench SHALL check: reset release with LOCKED_IN=1 from t0 -> DCM_RST_OUT high 16 cycles, READY_OUT rises 16+2+256 (±1) cycles later.
REQ-043 Bench SHALL check: LOCKED_IN held 0 -> a new 16-cycle DCM_RST_OUT pulse every 4096+16 cycles, RETRY_CNT_OUT incrementing, saturating at 255.
REQ-044 Bench SHALL check: D={2,3,5,0} in RUN -> CLK_OUT periods 2/3/5 with highs 1/2/3 cycles, channel 3 stays 0, CE_OUT one pulse per period.
REQ-045 Bench SHALL check: LOAD_IN with D0 changing 4->6 mid-period -> current 4-cycle period completes, next period is 6.
REQ-046 Bench SHALL check: SYNC_IN with P={0,1,2,9}, D=4 -> next-cycle counts {0,1,2,0}, with CE_OUT[0] and CE_OUT[3] high.
REQ-047 Bench SHALL check: LOCKED_IN drops in RUN -> outputs 0 within 3 cycles, READY_OUT=0, DCM_RST_OUT pulses, RETRY_CNT_OUT+1.
